imem_boot_loader: RTL and testbench
===================================

// Module: imem_boot_loader
// PURPOSE
//   Sits upstream of the single-cycle CPU. It receives a byte stream (header plus
//   program image), assembles little-endian 32-bit words and writes them into
//   instruction memory. It holds the CPU in reset until the image is fully written,
//   then releases it. It also reports done/error status and the loaded word count.
// PARAMETERS
//   ADDR_WIDTH  8  instruction-memory word-address width; max image = 2**ADDR_WIDTH words
// PORTS
//   clock        in   1             system clock, rising-edge
//   reset        in   1             synchronous, active-low (0 = reset)
//   start        in   1             1-cycle pulse: re-arm loader from DONE/ERR
//   rx_valid     in   1             byte-stream valid
//   rx_data      in   8             byte-stream data
//   rx_ready     out  1             loader accepts byte this cycle
//   imem_we      out  1             instruction-memory write strobe (1 cycle per word)
//   imem_addr    out  ADDR_WIDTH    word address for imem_we
//   imem_wdata   out  32            word for imem_we
//   cpu_reset    out  1             active-low reset to CPU; 0 = CPU held in reset
//   load_done    out  1             image fully written, CPU released
//   load_error   out  1             illegal header length
//   word_count   out  ADDR_WIDTH+1  words written so far
// BEHAVIOUR
//   - All outputs are registered. reset==0 at a clock edge puts the block in state LEN0.
//     All outputs reset to 0 (cpu_reset=0, rx_ready=0), and internal counters clear.
//   - Byte transfer: a byte is accepted at a rising edge when rx_valid && rx_ready.
//     rx_valid without rx_ready is ignored. Gaps in rx_valid are legal.
//   - rx_ready is 1 in LEN0, LEN1 and DATA, and 0 in DONE and ERR (it is also 0 in reset).
//   - FSM states: LEN0 -> LEN1 -> DATA -> DONE; LEN1 -> ERR.
//     LEN0: accepted byte -> len[7:0]; go to LEN1.
//     LEN1: accepted byte -> len[15:8].
//       If len==0 or len > 2**ADDR_WIDTH: go to ERR.
//       Otherwise go to DATA with byte_idx=0 and waddr=0.
//     DATA: accepted byte goes to word[8*byte_idx +: 8], so the first byte is bits 7:0.
//       byte_idx wraps 3 -> 0.
//       On the 4th byte: on the next cycle imem_we=1 for exactly one cycle, with
//       imem_addr=waddr and imem_wdata=the assembled word.
//       word_count increments in the same cycle that imem_we is high; waddr then advances.
//       The next word's bytes may be accepted during the imem_we cycle.
//       If the 4th byte completes word len-1, the FSM moves to DONE on that edge.
//     DONE: the final imem_we is seen in the first DONE cycle.
//       One cycle later, load_done=1 and cpu_reset=1; both hold.
//       Latency is 2 cycles from the last accepted byte to the CPU release.
//     ERR: load_error=1 from the cycle after entry. cpu_reset stays 0. No imem writes.
//   - start: honoured only in DONE or ERR.
//     It moves the FSM to LEN0 and clears load_done, load_error and word_count.
//     cpu_reset=0 on the next cycle, so the CPU is re-held.
//     start is ignored in LEN0, LEN1 and DATA.
//   - Reset mid-load: the partial word is discarded and not written. Already-written
//     words stay in memory, but word_count=0 and the loader restarts at the header.
//   - Arithmetic: len is unsigned 16-bit and compared at 17 bits. word_count saturates
//     at len. imem_addr never exceeds 2**ADDR_WIDTH-1.
// TESTING
//   1. Header 02 00, then 78 56 34 12 EF BE AD DE, back-to-back ->
//      we@addr0=0x12345678 and we@addr1=0xDEADBEEF.
//      load_done=cpu_reset=1 two cycles after the last byte; word_count=2; rx_ready=0.
//   2. Header 00 00 -> load_error=1, rx_ready=0, cpu_reset=0, no imem_we.
//      A start pulse then clears the error and returns to LEN0.
//   3. ADDR_WIDTH=8: header 01 01 (257) -> ERR.
//      Header 00 01 (256) with 1024 bytes -> last write at addr 0xFF;
//      word_count=256; load_done=1.
//   4. The same image as test 1 with random 0-5 cycle rx_valid gaps ->
//      identical imem write sequence and values.
//   5. reset=0 for 1 cycle after 6 data bytes -> the second word is never written;
//      outputs are 0. A fresh full load afterwards succeeds.
//   6. start during DATA is ignored. start in DONE -> cpu_reset=0 and load_done=0 on
//      the next cycle; a new header is accepted.

Source files
------------

// File: rtl/imem_boot_loader.sv
// Boot loader: receives a length header plus a little-endian byte image, writes
// 32-bit words into instruction memory and releases the CPU once the image is written.
module imem_boot_loader #(
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  rx_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_reset,
  output logic                  load_done,
  output logic                  load_error,
  output logic [ADDR_WIDTH:0]   word_count
);

  typedef enum logic [2:0] {LEN0, LEN1, DATA, DONE, ERR} state_t;

  localparam logic [16:0] MAX_LEN = 17'd1 << ADDR_WIDTH;

  state_t                state, state_d;
  logic [15:0]           len, len_d;
  logic [1:0]            byte_idx, byte_idx_d;
  logic [23:0]           word_lo, word_lo_d;
  logic [ADDR_WIDTH-1:0] waddr, waddr_d;
  logic                  rx_ready_d, imem_we_d, cpu_reset_d, load_done_d, load_error_d;
  logic [ADDR_WIDTH-1:0] imem_addr_d;
  logic [31:0]           imem_wdata_d;
  logic [ADDR_WIDTH:0]   word_count_d;
  logic                  accept;
  logic [16:0]           hdr_len;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= LEN0;
      len        <= '0;
      byte_idx   <= '0;
      word_lo    <= '0;
      waddr      <= '0;
      rx_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_reset  <= 1'b0;
      load_done  <= 1'b0;
      load_error <= 1'b0;
      word_count <= '0;
    end else begin
      state      <= state_d;
      len        <= len_d;
      byte_idx   <= byte_idx_d;
      word_lo    <= word_lo_d;
      waddr      <= waddr_d;
      rx_ready   <= rx_ready_d;
      imem_we    <= imem_we_d;
      imem_addr  <= imem_addr_d;
      imem_wdata <= imem_wdata_d;
      cpu_reset  <= cpu_reset_d;
      load_done  <= load_done_d;
      load_error <= load_error_d;
      word_count <= word_count_d;
    end
  end

  always_comb begin
    state_d      = state;
    len_d        = len;
    byte_idx_d   = byte_idx;
    word_lo_d    = word_lo;
    waddr_d      = waddr;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr;
    imem_wdata_d = imem_wdata;
    cpu_reset_d  = cpu_reset;
    load_done_d  = load_done;
    load_error_d = load_error;
    word_count_d = word_count;
    accept       = rx_valid && rx_ready;
    hdr_len      = {1'b0, rx_data, len[7:0]};

    case (state)
      LEN0: begin
        if (accept) begin
          len_d[7:0] = rx_data;
          state_d    = LEN1;
        end
      end
      LEN1: begin
        if (accept) begin
          len_d[15:8] = rx_data;
          if (hdr_len == 17'd0 || hdr_len > MAX_LEN) begin
            state_d = ERR;
          end else begin
            state_d    = DATA;
            byte_idx_d = '0;
            waddr_d    = '0;
          end
        end
      end
      DATA: begin
        if (accept) begin
          byte_idx_d = byte_idx + 2'd1;
          case (byte_idx)
            2'd0: word_lo_d[7:0]   = rx_data;
            2'd1: word_lo_d[15:8]  = rx_data;
            2'd2: word_lo_d[23:16] = rx_data;
            default: begin
              // Fourth byte goes straight into the write register; the next
              // word may start filling word_lo during the write cycle.
              imem_we_d    = 1'b1;
              imem_addr_d  = waddr;
              imem_wdata_d = {rx_data, word_lo};
              if (17'(word_count) < {1'b0, len})
                word_count_d = word_count + 1'b1;
              waddr_d = waddr + 1'b1;
              if (17'(waddr) + 17'd1 == {1'b0, len})
                state_d = DONE;
            end
          endcase
        end
      end
      DONE, ERR: begin
        if (state == DONE) begin
          cpu_reset_d = 1'b1;
          load_done_d = 1'b1;
        end else begin
          load_error_d = 1'b1;
        end
        if (start) begin
          state_d      = LEN0;
          cpu_reset_d  = 1'b0;
          load_done_d  = 1'b0;
          load_error_d = 1'b0;
          word_count_d = '0;
        end
      end
      default: state_d = LEN0;
    endcase

    rx_ready_d = (state_d == LEN0) || (state_d == LEN1) || (state_d == DATA);
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed self-checking bench for imem_boot_loader (ADDR_WIDTH = 8).
module tb_imem_boot_loader;
  localparam int unsigned AW = 8;

  logic          clock = 1'b0;
  logic          reset, start, rx_valid;
  logic [7:0]    rx_data;
  logic          rx_ready, imem_we, cpu_reset, load_done, load_error;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic [AW:0]   word_count;

  int tests = 0;
  int fails = 0;

  logic [AW-1:0] wr_addr[$];
  logic [31:0]   wr_data[$];
  logic [AW:0]   wr_cnt[$];

  logic [7:0] img1 [8] = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
  int         gaps [8] = '{0, 3, 1, 5, 2, 0, 4, 1};

  imem_boot_loader #(.ADDR_WIDTH(AW)) dut (
    .clock(clock), .reset(reset), .start(start), .rx_valid(rx_valid),
    .rx_data(rx_data), .rx_ready(rx_ready), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_reset(cpu_reset),
    .load_done(load_done), .load_error(load_error), .word_count(word_count)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (imem_we === 1'b1) begin
      wr_addr.push_back(imem_addr);
      wr_data.push_back(imem_wdata);
      wr_cnt.push_back(word_count);
    end
  end

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_cnt.delete();
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clock);
    while (rx_ready !== 1'b1 && n < 20) begin
      n++;
      @(negedge clock);
    end
    if (rx_ready !== 1'b1) begin
      tests++; fails++;
      $display("FAIL send_timeout rx_ready=%b required 1", rx_ready);
    end
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_img1_checked(input string tag);
    for (int i = 0; i < 8; i++) send_byte(img1[i]);
    tests++;
    if (imem_we !== 1'b1 || load_done !== 1'b0 || cpu_reset !== 1'b0 || rx_ready !== 1'b0) begin
      fails++;
      $display("FAIL %s_first_done_cycle we=%b done=%b cpu=%b rdy=%b required 1 0 0 0",
               tag, imem_we, load_done, cpu_reset, rx_ready);
    end
    tick();
    tests++;
    if (load_done !== 1'b1 || cpu_reset !== 1'b1 || word_count !== 9'd2 || rx_ready !== 1'b0 || imem_we !== 1'b0) begin
      fails++;
      $display("FAIL %s_release done=%b cpu=%b wc=%0d rdy=%b we=%b required 1 1 2 0 0",
               tag, load_done, cpu_reset, word_count, rx_ready, imem_we);
    end
    tests++;
    if (wr_addr.size() != 2) begin
      fails++;
      $display("FAIL %s_write_count got %0d required 2", tag, wr_addr.size());
    end else if (wr_addr[0] !== 8'h00 || wr_data[0] !== 32'h12345678 ||
                 wr_addr[1] !== 8'h01 || wr_data[1] !== 32'hDEADBEEF ||
                 wr_cnt[0] !== 9'd1 || wr_cnt[1] !== 9'd2) begin
      fails++;
      $display("FAIL %s_writes got %h:%h/%0d %h:%h/%0d required 00:12345678/1 01:deadbeef/2",
               tag, wr_addr[0], wr_data[0], wr_cnt[0], wr_addr[1], wr_data[1], wr_cnt[1]);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    tick(); tick();
    tests++;
    if (rx_ready !== 1'b0 || imem_we !== 1'b0 || imem_addr !== 8'h00 || imem_wdata !== 32'h0 ||
        cpu_reset !== 1'b0 || load_done !== 1'b0 || load_error !== 1'b0 || word_count !== 9'd0) begin
      fails++;
      $display("FAIL reset_outputs rdy=%b we=%b addr=%h wd=%h cpu=%b done=%b err=%b wc=%0d required all 0",
               rx_ready, imem_we, imem_addr, imem_wdata, cpu_reset, load_done, load_error, word_count);
    end
    reset = 1'b1;
    tick();
    tests++;
    if (rx_ready !== 1'b1 || cpu_reset !== 1'b0) begin
      fails++;
      $display("FAIL reset_release rdy=%b cpu=%b required 1 0", rx_ready, cpu_reset);
    end
  endtask

  task automatic test_basic_load();
    clear_log();
    send_byte(8'h02); send_byte(8'h00);
    tests++;
    if (cpu_reset !== 1'b0 || rx_ready !== 1'b1) begin
      fails++;
      $display("FAIL basic_header cpu=%b rdy=%b required 0 1", cpu_reset, rx_ready);
    end
    send_img1_checked("basic");
  endtask

  task automatic test_zero_len();
    pulse_start();
    clear_log();
    send_byte(8'h00); send_byte(8'h00);
    tests++;
    if (load_error !== 1'b0 || rx_ready !== 1'b0) begin
      fails++;
      $display("FAIL zero_entry err=%b rdy=%b required 0 0", load_error, rx_ready);
    end
    tick(); tick();
    tests++;
    if (load_error !== 1'b1 || rx_ready !== 1'b0 || cpu_reset !== 1'b0 || wr_addr.size() != 0) begin
      fails++;
      $display("FAIL zero_err err=%b rdy=%b cpu=%b writes=%0d required 1 0 0 0",
               load_error, rx_ready, cpu_reset, wr_addr.size());
    end
    pulse_start();
    tests++;
    if (load_error !== 1'b0 || rx_ready !== 1'b1 || word_count !== 9'd0) begin
      fails++;
      $display("FAIL zero_start err=%b rdy=%b wc=%0d required 0 1 0", load_error, rx_ready, word_count);
    end
  endtask

  task automatic test_max_len();
    int bad;
    clear_log();
    send_byte(8'h01); send_byte(8'h01);
    tick();
    tests++;
    if (load_error !== 1'b1 || rx_ready !== 1'b0) begin
      fails++;
      $display("FAIL len257_err err=%b rdy=%b required 1 0", load_error, rx_ready);
    end
    pulse_start();
    send_byte(8'h00); send_byte(8'h01);
    for (int i = 0; i < 256; i++)
      for (int k = 0; k < 4; k++)
        send_byte(8'(i + 64 * k));
    tick();
    tests++;
    if (load_done !== 1'b1 || cpu_reset !== 1'b1 || word_count !== 9'd256 || load_error !== 1'b0) begin
      fails++;
      $display("FAIL len256_done done=%b cpu=%b wc=%0d err=%b required 1 1 256 0",
               load_done, cpu_reset, word_count, load_error);
    end
    tests++;
    if (wr_addr.size() != 256) begin
      fails++;
      $display("FAIL len256_writes got %0d required 256", wr_addr.size());
    end else begin
      tests++;
      if (wr_addr[255] !== 8'hFF || wr_data[255] !== 32'hBF7F3FFF || wr_data[0] !== 32'hC0804000) begin
        fails++;
        $display("FAIL len256_ends last=%h:%h first=%h required ff:bf7f3fff c0804000",
                 wr_addr[255], wr_data[255], wr_data[0]);
      end
      bad = 0;
      for (int i = 0; i < 256; i++)
        if (wr_addr[i] !== 8'(i) || wr_cnt[i] !== 9'(i + 1)) bad++;
      tests++;
      if (bad != 0) begin
        fails++;
        $display("FAIL len256_sequence bad_entries=%0d required 0", bad);
      end
    end
  endtask

  task automatic test_gaps();
    pulse_start();
    clear_log();
    send_byte(8'h02); send_byte(8'h00);
    for (int i = 0; i < 8; i++) begin
      repeat (gaps[i]) tick();
      send_byte(img1[i]);
    end
    tick();
    tests++;
    if (load_done !== 1'b1 || cpu_reset !== 1'b1 || word_count !== 9'd2) begin
      fails++;
      $display("FAIL gaps_done done=%b cpu=%b wc=%0d required 1 1 2", load_done, cpu_reset, word_count);
    end
    tests++;
    if (wr_addr.size() != 2) begin
      fails++;
      $display("FAIL gaps_write_count got %0d required 2", wr_addr.size());
    end else if (wr_addr[0] !== 8'h00 || wr_data[0] !== 32'h12345678 ||
                 wr_addr[1] !== 8'h01 || wr_data[1] !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL gaps_writes got %h:%h %h:%h required 00:12345678 01:deadbeef",
               wr_addr[0], wr_data[0], wr_addr[1], wr_data[1]);
    end
  endtask

  task automatic test_reset_mid_load();
    pulse_start();
    clear_log();
    send_byte(8'h02); send_byte(8'h00);
    for (int i = 0; i < 6; i++) send_byte(img1[i]);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tests++;
    if (word_count !== 9'd0 || imem_we !== 1'b0 || rx_ready !== 1'b0 || cpu_reset !== 1'b0 ||
        load_done !== 1'b0 || imem_wdata !== 32'h0) begin
      fails++;
      $display("FAIL midreset_outputs wc=%0d we=%b rdy=%b cpu=%b done=%b wd=%h required all 0",
               word_count, imem_we, rx_ready, cpu_reset, load_done, imem_wdata);
    end
    repeat (3) tick();
    tests++;
    if (wr_addr.size() != 1 || wr_data[0] !== 32'h12345678) begin
      fails++;
      $display("FAIL midreset_writes count=%0d required 1 (word0 only)", wr_addr.size());
    end
    clear_log();
    send_byte(8'h02); send_byte(8'h00);
    send_img1_checked("after_reset");
  endtask

  task automatic test_start();
    pulse_start();
    clear_log();
    send_byte(8'h02); send_byte(8'h00);
    send_byte(img1[0]); send_byte(img1[1]);
    pulse_start();
    tests++;
    if (rx_ready !== 1'b1 || load_done !== 1'b0) begin
      fails++;
      $display("FAIL start_in_data rdy=%b done=%b required 1 0", rx_ready, load_done);
    end
    for (int i = 2; i < 8; i++) send_byte(img1[i]);
    tick();
    tests++;
    if (load_done !== 1'b1 || wr_addr.size() != 2 || wr_data[1] !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL start_ignored done=%b writes=%0d required 1 2", load_done, wr_addr.size());
    end
    pulse_start();
    tests++;
    if (cpu_reset !== 1'b0 || load_done !== 1'b0 || word_count !== 9'd0 || rx_ready !== 1'b1) begin
      fails++;
      $display("FAIL start_in_done cpu=%b done=%b wc=%0d rdy=%b required 0 0 0 1",
               cpu_reset, load_done, word_count, rx_ready);
    end
    clear_log();
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    tick();
    tests++;
    if (load_done !== 1'b1 || cpu_reset !== 1'b1 || word_count !== 9'd1 || wr_addr.size() != 1) begin
      fails++;
      $display("FAIL reload_done done=%b cpu=%b wc=%0d writes=%0d required 1 1 1 1",
               load_done, cpu_reset, word_count, wr_addr.size());
    end else if (wr_addr[0] !== 8'h00 || wr_data[0] !== 32'h44332211) begin
      fails++;
      $display("FAIL reload_write got %h:%h required 00:44332211", wr_addr[0], wr_data[0]);
    end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_zero_len();
    test_max_len();
    test_gaps();
    test_reset_mid_load();
    test_start();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
